ctrl_escrita_memoria: RTL and testbench
=======================================

// Module: ctrl_escrita_memoria
// PURPOSE
//  Sequencer for the memory write-data path; drives the 2-bit select of the store-data mux (B / merged / bit-count).
//  sw: single-cycle direct write of B. sh/sb: read-modify-write on the word-addressed data memory.
//  Sits between the main control FSM and the data memory; the main FSM pulses start and stalls until done.
// PARAMETERS
//  MEM_LAT   1   data-memory read latency in cycles (1..3); the wait phase lasts MEM_LAT cycles
// PORTS
//  clock          in   1   single system clock, all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  start          in   1   one-cycle request, sampled only in IDLE
//  store_type     in   2   00=sw, 01=sh, 10=sb, 11=illegal; sampled with start
//  addr           in   32  byte address; sampled with start
//  b_data         in   32  store source (register B); sampled with start
//  mem_rdata      in   32  data-memory read data, valid MEM_LAT cycles after mem_rd
//  mem_addr       out  32  word-aligned address {addr_q[31:2],2'b00}
//  mem_rd         out  1   read strobe, 1 cycle
//  mem_wr         out  1   write strobe, 1 cycle
//  mux_mem_dado   out  2   store-data mux select: 00=B, 01=merged word
//  merged_data    out  32  read word with new byte/half inserted (feeds mux input 01)
//  busy           out  1   high in every state except IDLE
//  done           out  1   1-cycle pulse, store complete
//  align_err      out  1   1-cycle pulse, misaligned/illegal request aborted without write
// BEHAVIOUR
//  Reset: state=IDLE; mem_rd=mem_wr=done=align_err=0; mux_mem_dado=00; busy=0; addr_q/b_q/type_q/merged_data=0.
//  Byte lanes little-endian: offset addr[1:0]=k -> byte lane bits [8k+7:8k]; half lane h=addr[1] -> bits [16h+15:16h].
//  States: IDLE, READ, WAIT, WRITE, DONE, ERR.
//  IDLE: on start, latch addr/b_data/store_type.
//   sw with addr[1:0]!=0, sh with addr[0]=1, or type 11 -> ERR.
//   sw aligned -> WRITE (mux_mem_dado=00).  sh/sb aligned -> READ.
//  READ: mem_rd=1 for one cycle, load wait counter with MEM_LAT-1 -> WAIT.
//  WAIT: count down; when counter==0 capture merged_data = mem_rdata with target lane
//   replaced by b_q[7:0] (sb) or b_q[15:0] (sh) -> WRITE (mux_mem_dado=01).
//  WRITE: mem_wr=1 for exactly one cycle; mem_addr and mux_mem_dado stable this cycle -> DONE.
//  DONE: done=1 one cycle, busy=1 -> IDLE.  ERR: align_err=1 one cycle, no mem_rd/mem_wr -> IDLE.
//  mux_mem_dado holds its value from the selecting transition through WRITE; returns to 00 in IDLE.
//  mem_addr constant from the cycle after start until return to IDLE.
//  Latency start->done pulse: sw 2 cycles; sh/sb 3+MEM_LAT cycles.
//  start while busy: ignored (no queueing). start on same edge as reset: reset wins.
//  Reset mid-operation: abort immediately, no write issued after reset edge, outputs at reset values.
//  merged_data retains its last value outside WAIT/WRITE.
//  mem_rd and mem_wr never both high; never more than one mem_wr per request.
// TESTING
//  sw addr=0x100 b=0xDEADBEEF -> one mem_wr, mem_addr=0x100, mux=00, done 2 cycles after start.
//  sb addr=0x102 b=0x000000AA, mem_rdata=0x11223344 -> mem_rd, then mem_wr merged=0x11AA3344, mux=01.
//  sh addr=0x206 b=0x0000BEEF, mem_rdata=0xCAFEF00D -> merged=0xBEEFF00D, mem_addr=0x204, done at 3+MEM_LAT.
//  sh addr=0x203 / sw addr=0x101 / type=11 -> align_err pulse, no mem_rd/mem_wr, busy back low next cycle.
//  Reset asserted in WAIT of an sb -> no mem_wr ever, all outputs zero next cycle; start during busy ignored.
//  MEM_LAT=3 run of sb -> capture on 3rd cycle after mem_rd; mem_rdata changed before that has no effect.

Source files
------------

// File: rtl/ctrl_escrita_memoria_if.sv
// ---------------------------------------------------------------------------
// ctrl_escrita_memoria_if
//   Bundle of request, data-memory and store-mux signals for the memory
//   write-data sequencer. Clock and reset stay outside the bundle.
//
//   Request side (from the main control FSM):
//     start         1   one-cycle store request
//     store_type    2   00=sw, 01=sh, 10=sb, 11=illegal
//     addr          32  byte address of the store
//     b_data        32  store source (register B)
//   Data-memory side:
//     mem_rdata     32  read data, valid MEM_LAT cycles after mem_rd
//     mem_addr      32  word-aligned address
//     mem_rd        1   read strobe
//     mem_wr        1   write strobe
//   Store-data mux / status:
//     mux_mem_dado  2   00=B, 01=merged word
//     merged_data   32  read word with new byte/half inserted
//     busy          1   sequencer not idle
//     done          1   store complete pulse
//     align_err     1   misaligned/illegal request aborted pulse
//
//   master : the environment (main FSM + data memory), drives the inputs
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface ctrl_escrita_memoria_if;

    logic        start;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] b_data;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mux_mem_dado;
    logic [31:0] merged_data;
    logic        busy;
    logic        done;
    logic        align_err;

    modport master (
        output start,
        output store_type,
        output addr,
        output b_data,
        output mem_rdata,
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mux_mem_dado,
        input  merged_data,
        input  busy,
        input  done,
        input  align_err
    );

    modport slave (
        input  start,
        input  store_type,
        input  addr,
        input  b_data,
        input  mem_rdata,
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mux_mem_dado,
        output merged_data,
        output busy,
        output done,
        output align_err
    );

endinterface

// File: rtl/ctrl_escrita_memoria.sv
// ---------------------------------------------------------------------------
// ctrl_escrita_memoria
//   Sequencer for the memory write-data path. It drives the select of the
//   store-data mux (B or merged word) and the data-memory strobes.
//     sw    : single-cycle direct write of B (mux = 00).
//     sh/sb : read-modify-write of the addressed word; the new half/byte is
//             inserted into the read word, which is then written (mux = 01).
//   Misaligned sw/sh and the illegal type 11 are aborted with an align_err
//   pulse and never touch the memory.
//
//   Parameters:
//     MEM_LAT   data-memory read latency in cycles (1..3)
//
//   Ports:
//     clock     system clock, all state updates on the rising edge
//     reset     synchronous, active-high
//     bus       ctrl_escrita_memoria_if.slave (request, memory, mux, status)
//
//   Latency from start to done: sw 2 cycles, sh/sb 3+MEM_LAT cycles.
// ---------------------------------------------------------------------------
module ctrl_escrita_memoria #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    ctrl_escrita_memoria_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_BAD = 2'b11
    } store_t;

    localparam logic [1:0] MUX_B      = 2'b00;
    localparam logic [1:0] MUX_MERGED = 2'b01;

    // Wait counter reload: the WAIT phase spans MEM_LAT cycles, the last one
    // being the cycle in which the counter reads zero and data is captured.
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    // Only the low half of B is ever inserted; a full-word store takes B
    // straight through mux input 00, so the upper half is not kept here.
    logic [15:0] b_q,      b_d;
    store_t      type_q,   type_d;
    logic [1:0]  cnt_q,    cnt_d;
    logic [1:0]  mux_q,    mux_d;
    logic [31:0] merged_q, merged_d;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Request cannot be served: word not on a word boundary, half on an odd
    // byte, or the reserved encoding.
    function automatic logic is_misaligned(input logic [1:0]  t,
                                           input logic [1:0]  off);
        logic bad;
        bad = 1'b0;
        case (t)
            ST_SW:   bad = (off != 2'b00);
            ST_SH:   bad = off[0];
            ST_SB:   bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane insertion: byte k lives at bits [8k+7:8k], half h
    // at bits [16h+15:16h]. All other lanes keep the value read from memory.
    function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                                input logic [15:0] src,
                                                input logic [1:0]  off,
                                                input store_t      t);
        logic [31:0] res;
        res = word;
        if (t == ST_SB) begin
            case (off)
                2'd0:    res[7:0]   = src[7:0];
                2'd1:    res[15:8]  = src[7:0];
                2'd2:    res[23:16] = src[7:0];
                default: res[31:24] = src[7:0];
            endcase
        end else begin
            if (off[1]) res[31:16] = src;
            else        res[15:0]  = src;
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        b_d      = b_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        mux_d    = mux_q;
        merged_d = merged_q;

        case (state_q)
            S_IDLE: begin
                mux_d = MUX_B;
                if (bus.start) begin
                    addr_d = bus.addr;
                    b_d    = bus.b_data[15:0];
                    type_d = store_t'(bus.store_type);
                    if (is_misaligned(bus.store_type, bus.addr[1:0])) begin
                        state_d = S_ERR;
                    end else if (bus.store_type == ST_SW) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    merged_d = insert_lane(bus.mem_rdata, b_q, addr_q[1:0], type_q);
                    mux_d    = MUX_MERGED;
                    state_d  = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            S_WRITE: begin
                state_d = S_DONE;
            end

            // The mux select is held through DONE and cleared on the way
            // back, so it reads 00 from the first IDLE cycle on.
            S_DONE, S_ERR: begin
                mux_d   = MUX_B;
                state_d = S_IDLE;
            end

            default: begin
                mux_d   = MUX_B;
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: reset clears every register, including the captured word, so
        // an operation aborted by reset leaves nothing behind that could be
        // written later. The check sits first so reset wins over start.
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            b_q      <= '0;
            type_q   <= ST_SW;
            cnt_q    <= '0;
            mux_q    <= MUX_B;
            merged_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values of the previous cycle regardless of statement order.
            state_q  <= state_d;
            addr_q   <= addr_d;
            b_q      <= b_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            mux_q    <= mux_d;
            merged_q <= merged_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: strobes and pulses are decoded from the state, so each lasts
    // exactly one cycle and mem_rd / mem_wr can never overlap.
    // -----------------------------------------------------------------------
    assign bus.mem_addr     = {addr_q[31:2], 2'b00};
    assign bus.mem_rd       = (state_q == S_READ);
    assign bus.mem_wr       = (state_q == S_WRITE);
    assign bus.mux_mem_dado = mux_q;
    assign bus.merged_data  = merged_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.align_err    = (state_q == S_ERR);

endmodule

// File: tb/tb_ctrl_escrita_memoria.sv
// ---------------------------------------------------------------------------
// tb_ctrl_escrita_memoria
//   Directed bench for the memory write-data sequencer. Two instances are
//   used: one with MEM_LAT=1 for the bulk of the cases and one with
//   MEM_LAT=3 for the longer read wait. Expected writes are queued when a
//   request is issued and popped by a monitor whenever mem_wr is seen.
// ---------------------------------------------------------------------------
module tb_ctrl_escrita_memoria;

    logic clk;
    logic reset;

    ctrl_escrita_memoria_if b1 ();
    ctrl_escrita_memoria_if b3 ();

    ctrl_escrita_memoria #(.MEM_LAT(1)) dut1 (
        .clock (clk),
        .reset (reset),
        .bus   (b1)
    );

    ctrl_escrita_memoria #(.MEM_LAT(3)) dut3 (
        .clock (clk),
        .reset (reset),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  mux;
        logic [31:0] data;
    } exp_t;

    exp_t sb1_q[$];
    exp_t sb3_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference merge built from masks and shifts.
    function automatic logic [31:0] model_merge(input logic [1:0] t, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] rd);
        logic [31:0] mask;
        logic [31:0] ins;
        int          sh;
        if (t == 2'b10) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
            ins  = (b & 32'h0000_00FF) << sh;
        end else begin
            sh   = 16 * int'(a[1]);
            mask = 32'h0000_FFFF << sh;
            ins  = (b & 32'h0000_FFFF) << sh;
        end
        return (rd & ~mask) | ins;
    endfunction

    // Scoreboard monitors: every write must match the oldest queued request.
    always @(negedge clk) begin
        if (b1.mem_wr) begin
            check("wr1_expected", (sb1_q.size() > 0), 1'b1);
            check("wr1_rd_excl", b1.mem_rd, 1'b0);
            if (sb1_q.size() > 0) begin
                exp_t e;
                e = sb1_q.pop_front();
                check("wr1_addr", b1.mem_addr, e.addr);
                check("wr1_mux", b1.mux_mem_dado, e.mux);
                if (e.mux == 2'b01) check("wr1_merged", b1.merged_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b3.mem_wr) begin
            check("wr3_expected", (sb3_q.size() > 0), 1'b1);
            check("wr3_rd_excl", b3.mem_rd, 1'b0);
            if (sb3_q.size() > 0) begin
                exp_t e;
                e = sb3_q.pop_front();
                check("wr3_addr", b3.mem_addr, e.addr);
                check("wr3_mux", b3.mux_mem_dado, e.mux);
                if (e.mux == 2'b01) check("wr3_merged", b3.merged_data, e.data);
            end
        end
    end

    // One request on the MEM_LAT=1 instance. With poke set, a conflicting
    // start is driven in the cycle after acceptance and must be ignored.
    task automatic do_store(input string tag, input logic [1:0] t, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] rd,
                            input logic [31:0] exp_merged, input int exp_lat,
                            input bit exp_err, input bit poke);
        int   cyc;
        int   n_rd;
        int   n_wr;
        exp_t e;
        n_rd = 0;
        n_wr = 0;
        if (!exp_err) begin
            e.addr = {a[31:2], 2'b00};
            e.mux  = (t == 2'b00) ? 2'b00 : 2'b01;
            e.data = exp_merged;
            sb1_q.push_back(e);
        end
        b1.start      = 1'b1;
        b1.store_type = t;
        b1.addr       = a;
        b1.b_data     = b;
        b1.mem_rdata  = rd;
        tick();
        cyc = 1;
        while (cyc <= 20) begin
            if (b1.mem_rd) n_rd++;
            if (b1.mem_wr) n_wr++;
            if (cyc == 1) check({tag, "_busy"}, b1.busy, 1'b1);
            check({tag, "_mem_addr"}, b1.mem_addr, {a[31:2], 2'b00});
            if (poke && cyc == 1) begin
                b1.start      = 1'b1;
                b1.store_type = 2'b00;
                b1.addr       = 32'h0000_0400;
                b1.b_data     = 32'h1234_5678;
            end else begin
                b1.start = 1'b0;
            end
            if (b1.done || b1.align_err) break;
            tick();
            cyc++;
        end
        b1.start = 1'b0;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_done"}, b1.done, !exp_err);
        check({tag, "_align_err"}, b1.align_err, exp_err);
        check({tag, "_n_rd"}, n_rd, (exp_err || t == 2'b00) ? 0 : 1);
        check({tag, "_n_wr"}, n_wr, exp_err ? 0 : 1);
        tick();
        check({tag, "_idle_busy"}, b1.busy, 1'b0);
        check({tag, "_idle_pulse"}, {b1.done, b1.align_err}, 2'b00);
        check({tag, "_idle_mux"}, b1.mux_mem_dado, 2'b00);
        if (!exp_err && t != 2'b00) check({tag, "_merged_hold"}, b1.merged_data, exp_merged);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;

        reset         = 1'b1;
        b1.start      = 1'b0;
        b1.store_type = 2'b00;
        b1.addr       = '0;
        b1.b_data     = '0;
        b1.mem_rdata  = '0;
        b3.start      = 1'b0;
        b3.store_type = 2'b00;
        b3.addr       = '0;
        b3.b_data     = '0;
        b3.mem_rdata  = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy", b1.busy, 1'b0);
        check("rst_strobes", {b1.mem_rd, b1.mem_wr}, 2'b00);
        check("rst_pulses", {b1.done, b1.align_err}, 2'b00);
        check("rst_mux", b1.mux_mem_dado, 2'b00);
        check("rst_merged", b1.merged_data, 32'h0);
        check("rst_mem_addr", b1.mem_addr, 32'h0);
        check("rst3_busy", b3.busy, 1'b0);
        reset = 1'b0;
        tick();

        // Functional stores
        do_store("sw_100", 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'h0, 2, 1'b0, 1'b0);
        do_store("sb_102", 2'b10, 32'h0000_0102, 32'h0000_00AA, 32'h1122_3344,
                 32'h11AA_3344, 4, 1'b0, 1'b0);
        do_store("sh_206", 2'b01, 32'h0000_0206, 32'h0000_BEEF, 32'hCAFE_F00D,
                 32'hBEEF_F00D, 4, 1'b0, 1'b1);
        do_store("sb_007", 2'b10, 32'h0000_0007, 32'hFFFF_FFC3, 32'h0123_4567,
                 model_merge(2'b10, 32'h7, 32'hFFFF_FFC3, 32'h0123_4567), 4, 1'b0, 1'b0);
        do_store("sb_008", 2'b10, 32'h0000_0008, 32'h0000_0099, 32'h8899_AABB,
                 model_merge(2'b10, 32'h8, 32'h0000_0099, 32'h8899_AABB), 4, 1'b0, 1'b0);
        do_store("sh_200", 2'b01, 32'h0000_0200, 32'hABCD_1357, 32'h7654_3210,
                 model_merge(2'b01, 32'h200, 32'hABCD_1357, 32'h7654_3210), 4, 1'b0, 1'b0);
        do_store("sw_104", 2'b00, 32'h0000_0104, 32'h0BAD_F00D, 32'h0, 32'h0, 2, 1'b0, 1'b1);

        // Aborted requests
        do_store("err_sh_203", 2'b01, 32'h0000_0203, 32'h0000_1111, 32'h0, 32'h0, 1, 1'b1, 1'b0);
        do_store("err_sw_101", 2'b00, 32'h0000_0101, 32'h2222_2222, 32'h0, 32'h0, 1, 1'b1, 1'b0);
        do_store("err_type11", 2'b11, 32'h0000_0100, 32'h3333_3333, 32'h0, 32'h0, 1, 1'b1, 1'b0);

        // Reset during WAIT of an sb, with start on the same edge as reset
        b1.store_type = 2'b10;
        b1.addr       = 32'h0000_0101;
        b1.b_data     = 32'h0000_00AA;
        b1.mem_rdata  = 32'h1122_3344;
        b1.start      = 1'b1;
        tick();
        b1.start = 1'b0;
        check("rstmid_rd", b1.mem_rd, 1'b1);
        tick();
        check("rstmid_in_wait", {b1.busy, b1.mem_rd, b1.mem_wr}, 3'b100);
        reset         = 1'b1;
        b1.start      = 1'b1;
        b1.store_type = 2'b00;
        b1.addr       = 32'h0000_0500;
        tick();
        check("rstmid_busy", b1.busy, 1'b0);
        check("rstmid_strobes", {b1.mem_rd, b1.mem_wr}, 2'b00);
        check("rstmid_pulses", {b1.done, b1.align_err}, 2'b00);
        check("rstmid_mux", b1.mux_mem_dado, 2'b00);
        check("rstmid_merged", b1.merged_data, 32'h0);
        check("rstmid_mem_addr", b1.mem_addr, 32'h0);
        reset    = 1'b0;
        b1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstmid_no_wr", b1.mem_wr, 1'b0);
            check("rstmid_stay_idle", b1.busy, 1'b0);
        end

        // MEM_LAT=3: data is captured only on the third cycle after mem_rd
        begin
            exp_t e;
            e.addr = 32'h0;
            e.mux  = 2'b01;
            e.data = 32'h5AB2_C3D4;
            sb3_q.push_back(e);
        end
        b3.store_type = 2'b10;
        b3.addr       = 32'h0000_0003;
        b3.b_data     = 32'h0000_005A;
        b3.mem_rdata  = 32'hFFFF_FFFF;
        b3.start      = 1'b1;
        tick();
        b3.start = 1'b0;
        cyc = 1;
        while (cyc <= 20) begin
            if (cyc == 1) check("lat3_rd", b3.mem_rd, 1'b1);
            b3.mem_rdata = (cyc == 4) ? 32'hA1B2_C3D4 : (32'h0F0F_0F0F ^ 32'(cyc));
            if (b3.done) break;
            tick();
            cyc++;
        end
        check("lat3_latency", cyc, 6);
        check("lat3_done", b3.done, 1'b1);
        tick();
        check("lat3_idle_busy", b3.busy, 1'b0);
        check("lat3_merged_hold", b3.merged_data, 32'h5AB2_C3D4);

        tick();
        check("sb1_drained", sb1_q.size(), 0);
        check("sb3_drained", sb3_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
